// File: rtl/obc_da_pkg.sv
// Shared types and default sizes for the OBC distributed-arithmetic sequencer.
// One sequencer instance serves one output coefficient and its ROM.
package obc_da_pkg;

   localparam int N_PTS  = 16;
   localparam int W_DEF  = 16;
   localparam int RW_DEF = 32;
   localparam int AW_DEF = 48;
   localparam int CNT_W  = $clog2(W_DEF);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/obc_plane_shifter.sv
// Sixteen parallel W-bit load/shift registers; their LSBs form the current bit-plane.
// Zero fill empties every register after W shifts, so xbit is 0 outside the shift phase.
module obc_plane_shifter
   import obc_da_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 shift,
   input  logic [N_PTS*W-1:0]   data,
   output logic [N_PTS-1:0]     xbit
);

   logic [W-1:0] sr [N_PTS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_PTS; k++) sr[k] <= '0;
      end else if (load) begin
         for (int k = 0; k < N_PTS; k++) sr[k] <= data[k*W +: W];
      end else if (shift) begin
         for (int k = 0; k < N_PTS; k++) sr[k] <= sr[k] >> 1;
      end
   end

   for (genvar g = 0; g < N_PTS; g++) begin : g_lsb
      assign xbit[g] = sr[g][0];
   end

endmodule

// File: rtl/obc_da_sequencer.sv
// Bit-plane sequencer and shift-accumulator feeding one 16-input OBC DA ROM.
//  state | meaning
//  IDLE  | waiting for a sample block, in_ready high
//  SHIFT | presenting plane n (LSB first), accumulating rom_in << n
//  DONE  | out_data holds the finished term until out_ready
module obc_da_sequencer
   import obc_da_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int RW = RW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N_PTS*W-1:0]   in_data,
   input  logic [AW-1:0]        offset,
   output logic [N_PTS-1:0]     xbit,
   output logic                 m,
   input  logic [RW-1:0]        rom_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AW-1:0]        out_data,
   output logic                 busy
);

   localparam int NW = $clog2(W);

   state_t          state_q, state_d;
   logic [NW-1:0]   n_q;
   logic [AW-1:0]   acc_q;
   logic [AW-1:0]   rom_ext;
   logic            m_q;
   logic            accept;
   logic            last;

   assign accept  = in_valid && (state_q == IDLE);
   assign last    = (n_q == NW'(W-1));
   assign rom_ext = AW'(signed'(rom_in));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = SHIFT;
         SHIFT:   if (last)      state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // m is registered, so it is raised one plane early to line up with plane W-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         n_q     <= '0;
         acc_q   <= '0;
         m_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= (state_q == SHIFT) && (n_q == NW'(W-2));
         if (accept) begin
            acc_q <= offset;
            n_q   <= '0;
         end else if (state_q == SHIFT) begin
            acc_q <= acc_q + (rom_ext << n_q);
            n_q   <= n_q + 1'b1;
         end
      end
   end

   obc_plane_shifter #(.W(W)) u_shifter (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .shift (state_q == SHIFT),
      .data  (in_data),
      .xbit  (xbit)
   );

   assign m         = m_q;
   assign out_data  = acc_q;
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == SHIFT) || (state_q == DONE);

endmodule
